// File: rtl/ddr_pmon_lock_seq_pkg.sv
// Shared types and constants for the PMON lock-detect measurement sequencer.
package ddr_pmon_pkg;

  localparam int PMON_RES_W   = 24;
  localparam int PMON_MIN_GAP = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_ARM  = 3'd2,
    ST_WAIT = 3'd3,
    ST_EVAL = 3'd4,
    ST_DONE = 3'd5
  } pmon_seq_state_t;

endpackage

// File: rtl/ddr_pmon_lock_seq_if.sv
// Handshake between the lock sequencer (master) and the PMON frequency detector (slave).
// o_meas_en high opens a count window; the detector raises i_meas_done with
// i_meas_result valid and may hold both until it sees the next enable rising edge.
interface ddr_pmon_lock_seq_if
  import ddr_pmon_pkg::*;
#(
  parameter int RES_W = PMON_RES_W
) ();

  logic             o_meas_en;
  logic             i_meas_done;
  logic [RES_W-1:0] i_meas_result;

  modport master (output o_meas_en, input i_meas_done, input i_meas_result);
  modport slave  (input o_meas_en, output i_meas_done, output i_meas_result);

endinterface

// File: rtl/ddr_pmon_lock_seq_win_cmp.sv
// Combinational window check: pass when cmp-range <= result <= cmp+range,
// with both bounds clamped to the representable result range.
module ddr_pmon_win_cmp #(
  parameter int RES_W = 24
) (
  input  logic [RES_W-1:0] cmp,
  input  logic [9:0]       win_range,
  input  logic [RES_W-1:0] result,
  output logic             pass
);

  logic [RES_W:0] range_w;
  logic [RES_W:0] lo_wide;
  logic [RES_W:0] hi_wide;
  logic [RES_W:0] lo;
  logic [RES_W:0] hi;

  // One extra bit exposes the borrow/carry used for clamping.
  always_comb begin
    range_w = {{(RES_W - 9){1'b0}}, win_range};
    lo_wide = {1'b0, cmp} - range_w;
    hi_wide = {1'b0, cmp} + range_w;
    lo      = lo_wide[RES_W] ? '0 : lo_wide;
    hi      = hi_wide[RES_W] ? {1'b0, {RES_W{1'b1}}} : hi_wide;
    pass    = ({1'b0, result} >= lo) && ({1'b0, result} <= hi);
  end

endmodule

// File: rtl/ddr_pmon_lock_seq.sv
// PMON lock sequencer: repeats detector count windows until enough consecutive
// in-window results, attempt exhaustion or timeout. Optional min/max history: DDR_PMON_LOCK_SEQ_HIST_EN.
module ddr_pmon_lock_seq
  import ddr_pmon_pkg::*;
#(
  parameter int RES_W   = PMON_RES_W,
  parameter int MEAS_W  = 8,
  parameter int TO_W    = 16,
  parameter int MIN_GAP = PMON_MIN_GAP
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [RES_W-1:0]     i_cmp,
  input  logic [9:0]           i_range,
  input  logic [3:0]           i_pass_req,
  input  logic [MEAS_W-1:0]    i_max_meas,
  input  logic [TO_W-1:0]      i_timeout,
  input  logic [3:0]           i_gap,
  ddr_pmon_lock_seq_if.master  det,
  output logic                 o_busy,
  output logic                 o_locked,
  output logic                 o_fail,
  output logic                 o_timeout,
  output logic [RES_W-1:0]     o_last_result,
  output logic [MEAS_W-1:0]    o_meas_cnt,
  output logic [3:0]           o_pass_streak,
`ifdef DDR_PMON_LOCK_SEQ_HIST_EN
  output logic [RES_W-1:0]     o_min_result,
  output logic [RES_W-1:0]     o_max_result,
`endif
  output pmon_seq_state_t      o_state
);

  logic [3:0]        gap_cnt;
  logic [2:0]        arm_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [3:0]        eff_gap;
  logic [3:0]        eff_req;
  logic [MEAS_W-1:0] cnt_inc;
  logic [3:0]        streak_inc;
  logic              pass;

  ddr_pmon_win_cmp #(.RES_W(RES_W)) u_win_cmp (
    .cmp       (i_cmp),
    .win_range (i_range),
    .result    (det.i_meas_result),
    .pass      (pass)
  );

  always_comb begin
    eff_gap    = (i_gap < 4'(MIN_GAP)) ? 4'(MIN_GAP) : i_gap;
    eff_req    = (i_pass_req == 4'd0) ? 4'd1 : i_pass_req;
    cnt_inc    = (&o_meas_cnt) ? o_meas_cnt : o_meas_cnt + MEAS_W'(1);
    streak_inc = !pass ? 4'd0 : ((&o_pass_streak) ? o_pass_streak : o_pass_streak + 4'd1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_state       <= ST_IDLE;
      det.o_meas_en <= 1'b0;
      o_busy        <= 1'b0;
      o_locked      <= 1'b0;
      o_fail        <= 1'b0;
      o_timeout     <= 1'b0;
      o_last_result <= '0;
      o_meas_cnt    <= '0;
      o_pass_streak <= '0;
      gap_cnt       <= '0;
      arm_cnt       <= '0;
      to_cnt        <= '0;
`ifdef DDR_PMON_LOCK_SEQ_HIST_EN
      o_min_result  <= '0;
      o_max_result  <= '0;
`endif
    end else if (i_abort) begin
      // Abort keeps counters and flags for post-mortem inspection.
      o_state       <= ST_IDLE;
      det.o_meas_en <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      case (o_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            o_locked      <= 1'b0;
            o_fail        <= 1'b0;
            o_timeout     <= 1'b0;
            o_meas_cnt    <= '0;
            o_pass_streak <= '0;
            o_busy        <= 1'b1;
            gap_cnt       <= '0;
            o_state       <= ST_GAP;
`ifdef DDR_PMON_LOCK_SEQ_HIST_EN
            o_min_result  <= '1;
            o_max_result  <= '0;
`endif
          end
        end
        ST_GAP: begin
          if (gap_cnt >= eff_gap - 4'd1) begin
            o_state       <= ST_ARM;
            det.o_meas_en <= 1'b1;
            arm_cnt       <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        ST_ARM: begin
          // A done still high here belongs to the previous window.
          if (arm_cnt != 3'd3) arm_cnt <= arm_cnt + 3'd1;
          if (arm_cnt == 3'd3 && !det.i_meas_done) begin
            o_state <= ST_WAIT;
            to_cnt  <= '0;
          end
        end
        ST_WAIT: begin
          if (det.i_meas_done) begin
            o_state       <= ST_EVAL;
            det.o_meas_en <= 1'b0;
          end else if (i_timeout != '0 && to_cnt + TO_W'(1) == i_timeout) begin
            o_timeout     <= 1'b1;
            o_fail        <= 1'b1;
            o_busy        <= 1'b0;
            det.o_meas_en <= 1'b0;
            o_state       <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_EVAL: begin
          o_last_result <= det.i_meas_result;
          o_meas_cnt    <= cnt_inc;
          o_pass_streak <= streak_inc;
`ifdef DDR_PMON_LOCK_SEQ_HIST_EN
          if (o_meas_cnt == '0 || det.i_meas_result < o_min_result) o_min_result <= det.i_meas_result;
          if (o_meas_cnt == '0 || det.i_meas_result > o_max_result) o_max_result <= det.i_meas_result;
`endif
          if (streak_inc >= eff_req) begin
            o_locked <= 1'b1;
            o_busy   <= 1'b0;
            o_state  <= ST_DONE;
          end else if (i_max_meas != '0 && cnt_inc >= i_max_meas) begin
            o_fail  <= 1'b1;
            o_busy  <= 1'b0;
            o_state <= ST_DONE;
          end else begin
            gap_cnt <= '0;
            o_state <= ST_GAP;
          end
        end
        default: begin
          o_state       <= ST_IDLE;
          det.o_meas_en <= 1'b0;
          o_busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_pmon_lock_seq.sv
// Bench for ddr_pmon_lock_seq: a behavioural detector drives the handshake and a
// sequence-level reference model predicts flags, counters and per-window streaks.
`timescale 1ns/1ps
module tb_ddr_pmon_lock_seq;
  import ddr_pmon_pkg::*;

  localparam int     RES_W   = 24;
  localparam int     MEAS_W  = 8;
  localparam int     TO_W    = 16;
  localparam longint RES_MAX = (64'd1 << RES_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [RES_W-1:0]  cmp = '0;
  logic [9:0]        range_v = '0;
  logic [3:0]        pass_req = '0;
  logic [MEAS_W-1:0] max_meas = '0;
  logic [TO_W-1:0]   timeout = '0;
  logic [3:0]        gap = '0;
  logic              busy, locked, fail, timeout_f;
  logic [RES_W-1:0]  last_result;
  logic [MEAS_W-1:0] meas_cnt;
  logic [3:0]        pass_streak;
  pmon_seq_state_t   state;
`ifdef DDR_PMON_LOCK_SEQ_HIST_EN
  logic [RES_W-1:0]  min_result, max_result;
`endif

  ddr_pmon_lock_seq_if #(.RES_W(RES_W)) det ();

  ddr_pmon_lock_seq #(.RES_W(RES_W), .MEAS_W(MEAS_W), .TO_W(TO_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_cmp(cmp), .i_range(range_v), .i_pass_req(pass_req), .i_max_meas(max_meas),
    .i_timeout(timeout), .i_gap(gap), .det(det.master),
    .o_busy(busy), .o_locked(locked), .o_fail(fail), .o_timeout(timeout_f),
    .o_last_result(last_result), .o_meas_cnt(meas_cnt), .o_pass_streak(pass_streak),
`ifdef DDR_PMON_LOCK_SEQ_HIST_EN
    .o_min_result(min_result), .o_max_result(max_result),
`endif
    .o_state(state)
  );

  int vectors = 0;
  int miscompares = 0;

  // detector model and streak monitor
  logic [RES_W-1:0] res_q[$];
  logic [3:0]       exp_q[$];
  logic [3:0]       obs_q[$];
  int  det_delay = 6;
  int  clr_lat = 0;
  bit  det_mute = 0;
  bit  fresh = 0;
  int  stale_evals = 0;

  initial begin : detector
    int k;
    logic en_d;
    logic [MEAS_W-1:0] cnt_d;
    k = 0; en_d = 1'b0; cnt_d = '0;
    det.i_meas_done = 1'b0;
    det.i_meas_result = '0;
    forever begin
      @(negedge clk);
      if (meas_cnt > cnt_d) begin
        obs_q.push_back(pass_streak);
        if (!fresh) stale_evals++;
      end
      cnt_d = meas_cnt;
      if (det.o_meas_en && !en_d) begin k = 0; fresh = 0; end
      else if (det.o_meas_en) k++;
      if (det.o_meas_en) begin
        if (k == clr_lat) det.i_meas_done = 1'b0;
        else if (k == clr_lat + det_delay && !det_mute && res_q.size() > 0) begin
          det.i_meas_result = res_q.pop_front();
          det.i_meas_done = 1'b1;
          fresh = 1;
        end
      end
      en_d = det.o_meas_en;
    end
  end

  // reference model
  bit     m_locked, m_fail;
  int     m_cnt, m_streak;
  longint m_last, m_min, m_max;

  function automatic bit in_win(longint c, longint r, longint v);
    longint lo, hi;
    lo = c - r; if (lo < 0) lo = 0;
    hi = c + r; if (hi > RES_MAX) hi = RES_MAX;
    return (v >= lo) && (v <= hi);
  endfunction

  task automatic model_seq(input longint c, input longint r, input int req, input int mx,
                           input logic [RES_W-1:0] s[$]);
    int eff_req;
    eff_req = (req == 0) ? 1 : req;
    m_locked = 0; m_fail = 0; m_cnt = 0; m_streak = 0; m_last = 0; m_min = RES_MAX; m_max = 0;
    exp_q.delete();
    foreach (s[i]) begin
      if (m_locked || m_fail) break;
      m_cnt = (m_cnt == (1 << MEAS_W) - 1) ? m_cnt : m_cnt + 1;
      m_streak = in_win(c, r, s[i]) ? ((m_streak == 15) ? 15 : m_streak + 1) : 0;
      exp_q.push_back(4'(m_streak));
      m_last = s[i];
      if (s[i] < m_min) m_min = s[i];
      if (s[i] > m_max) m_max = s[i];
      if (m_streak >= eff_req) m_locked = 1;
      else if (mx != 0 && m_cnt >= mx) m_fail = 1;
    end
  endtask

  // driver: program CSRs, pulse start, wait for the sequence to finish, check results
  task automatic run_seq(input string name, input logic [RES_W-1:0] c, input logic [9:0] r,
                         input logic [3:0] req, input logic [MEAS_W-1:0] mx,
                         input logic [TO_W-1:0] to, input int dly);
    logic [RES_W-1:0] stim[$];
    int n;
    stim = res_q;
    model_seq(c, r, req, mx, stim);
    @(negedge clk);
    cmp = c; range_v = r; pass_req = req; max_meas = mx; timeout = to;
    det_delay = dly; det_mute = 0; obs_q.delete(); stale_evals = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy: got %b want 0", name, busy); end
    vectors++; if (locked !== m_locked) begin miscompares++; $display("FAIL %s locked: got %b want %b", name, locked, m_locked); end
    vectors++; if (fail !== m_fail) begin miscompares++; $display("FAIL %s fail: got %b want %b", name, fail, m_fail); end
    vectors++; if (timeout_f !== 1'b0) begin miscompares++; $display("FAIL %s timeout: got %b want 0", name, timeout_f); end
    vectors++; if (meas_cnt !== MEAS_W'(m_cnt)) begin miscompares++; $display("FAIL %s meas_cnt: got %0d want %0d", name, meas_cnt, m_cnt); end
    vectors++; if (pass_streak !== 4'(m_streak)) begin miscompares++; $display("FAIL %s streak: got %0d want %0d", name, pass_streak, m_streak); end
    vectors++; if (last_result !== RES_W'(m_last)) begin miscompares++; $display("FAIL %s last_result: got %h want %h", name, last_result, m_last); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL %s eval_count: got %0d want %0d", name, obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL %s streak[%0d]: got %0d want %0d", name, i, obs_q[i], exp_q[i]); end
      end
    end
    vectors++; if (stale_evals != 0) begin miscompares++; $display("FAIL %s stale_evals: got %0d want 0", name, stale_evals); end
`ifdef DDR_PMON_LOCK_SEQ_HIST_EN
    vectors++; if (min_result !== RES_W'(m_min)) begin miscompares++; $display("FAIL %s min: got %h want %h", name, min_result, m_min); end
    vectors++; if (max_result !== RES_W'(m_max)) begin miscompares++; $display("FAIL %s max: got %h want %h", name, max_result, m_max); end
`endif
    res_q.delete();
  endtask

  task automatic wait_en(input string name);
    int n;
    n = 0;
    while (det.o_meas_en !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vectors++; if (det.o_meas_en !== 1'b1) begin miscompares++; $display("FAIL %s enable_rise: got %b want 1", name, det.o_meas_en); end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if ({busy, locked, fail, timeout_f, det.o_meas_en} !== 5'b0) begin miscompares++; $display("FAIL reset flags: got %b want 00000", {busy, locked, fail, timeout_f, det.o_meas_en}); end
    vectors++; if (meas_cnt !== '0 || pass_streak !== '0) begin miscompares++; $display("FAIL reset counters: got %0d/%0d want 0/0", meas_cnt, pass_streak); end
    vectors++; if (last_result !== '0) begin miscompares++; $display("FAIL reset last_result: got %h want 0", last_result); end
    vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL reset state: got %0d want %0d", state, ST_IDLE); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock;
    res_q = '{24'd1005, 24'd992, 24'd1008};
    run_seq("lock3", 24'd1000, 10'd8, 4'd3, 8'd0, 16'd0, 6);
  endtask

  task automatic test_exhaust;
    res_q = '{24'd1000, 24'd1009, 24'd1000, 24'd991};
    run_seq("exhaust", 24'd1000, 10'd8, 4'd2, 8'd4, 16'd0, 7);
  endtask

  task automatic test_saturation;
    res_q = '{24'd0};        run_seq("sat_lo_pass", 24'd5, 10'd20, 4'd1, 8'd1, 16'd0, 5);
    res_q = '{24'd26};       run_seq("sat_lo_miss", 24'd5, 10'd20, 4'd1, 8'd1, 16'd0, 5);
    res_q = '{24'hFFFFFF};   run_seq("sat_hi_pass", 24'hFFFFF0, 10'h3FF, 4'd0, 8'd1, 16'd0, 5);
    res_q = '{24'hFFFBF0};   run_seq("sat_hi_miss", 24'hFFFFF0, 10'h3FF, 4'd1, 8'd1, 16'd0, 5);
  endtask

  task automatic test_gap;
    int gaps[5] = '{0, 3, 4, 7, 15};
    foreach (gaps[g]) begin
      int j, want;
      want = (gaps[g] < PMON_MIN_GAP) ? PMON_MIN_GAP : gaps[g];
      res_q = '{24'd1000};
      @(negedge clk);
      cmp = 24'd1000; range_v = 10'd8; pass_req = 4'd1; max_meas = 8'd1; timeout = '0;
      gap = 4'(gaps[g]); det_delay = 6; det_mute = 0; obs_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      j = 0;
      while (det.o_meas_en !== 1'b1 && j < 64) begin @(negedge clk); j++; end
      vectors++; if (j != want) begin miscompares++; $display("FAIL gap%0d enable_low_cycles: got %0d want %0d", gaps[g], j, want); end
      j = 0;
      while (busy && j < 200) begin @(negedge clk); j++; end
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL gap%0d locked: got %b want 1", gaps[g], locked); end
    end
    gap = '0;
    res_q.delete();
  endtask

  task automatic test_stale_done;
    clr_lat = 3;
    res_q = '{24'd1000, 24'd1003};
    run_seq("stale3", 24'd1000, 10'd8, 4'd2, 8'd0, 16'd0, 6);
    clr_lat = 7;
    res_q = '{24'd500, 24'd2000};
    run_seq("stale7", 24'd1000, 10'd8, 4'd1, 8'd2, 16'd0, 6);
    clr_lat = 0;
  endtask

  task automatic test_timeout;
    @(negedge clk);
    cmp = 24'd1000; range_v = 10'd8; pass_req = 4'd1; max_meas = 8'd0; timeout = 16'd50;
    det_mute = 1; res_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en("timeout");
    repeat (53) @(negedge clk);
    vectors++; if (timeout_f !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b want 0", timeout_f); end
    @(negedge clk);
    vectors++; if ({timeout_f, fail, locked, busy} !== 4'b1100) begin miscompares++; $display("FAIL timeout_flags: got %b want 1100", {timeout_f, fail, locked, busy}); end
    vectors++; if (meas_cnt !== '0) begin miscompares++; $display("FAIL timeout_cnt: got %0d want 0", meas_cnt); end
    @(negedge clk);
    vectors++; if (det.o_meas_en !== 1'b0) begin miscompares++; $display("FAIL timeout_enable: got %b want 0", det.o_meas_en); end
    det_mute = 0;
  endtask

  task automatic test_done_wins;
    int n;
    res_q = '{24'd1000};
    run_seq("done_wins", 24'd1000, 10'd8, 4'd1, 8'd0, 16'd20, 23);
    res_q = '{24'd1000};
    @(negedge clk);
    timeout = 16'd20; det_delay = 24; pass_req = 4'd1; max_meas = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    vectors++; if ({timeout_f, fail, locked} !== 3'b110) begin miscompares++; $display("FAIL late_done flags: got %b want 110", {timeout_f, fail, locked}); end
    vectors++; if (meas_cnt !== '0) begin miscompares++; $display("FAIL late_done cnt: got %0d want 0", meas_cnt); end
    res_q.delete();
    timeout = '0;
  endtask

  task automatic test_abort;
    int n;
    res_q = '{24'd1001};
    @(negedge clk);
    cmp = 24'd1000; range_v = 10'd8; pass_req = 4'd3; max_meas = 8'd0; timeout = '0; det_delay = 6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if ({timeout_f, fail} !== 2'b00) begin miscompares++; $display("FAIL abort start_clears: got %b want 00", {timeout_f, fail}); end
    n = 0;
    while (meas_cnt !== 8'd1 && n < 200) begin @(negedge clk); n++; end
    wait_en("abort");
    repeat (8) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    vectors++; if ({busy, det.o_meas_en} !== 2'b00) begin miscompares++; $display("FAIL abort busy_en: got %b want 00", {busy, det.o_meas_en}); end
    vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL abort state: got %0d want %0d", state, ST_IDLE); end
    vectors++; if (meas_cnt !== 8'd1 || pass_streak !== 4'd1) begin miscompares++; $display("FAIL abort hold: got %0d/%0d want 1/1", meas_cnt, pass_streak); end
    vectors++; if ({locked, fail} !== 2'b00) begin miscompares++; $display("FAIL abort flags: got %b want 00", {locked, fail}); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort start_ignored: got %b want 0", busy); end
    res_q = '{24'd1000, 24'd1000, 24'd1000};
    run_seq("after_abort", 24'd1000, 10'd8, 4'd3, 8'd0, 16'd0, 6);
  endtask

  task automatic test_random;
    for (int it = 0; it < 25; it++) begin
      logic [RES_W-1:0] c;
      logic [9:0] r;
      int mx;
      longint v;
      case (it % 4)
        0: c = RES_W'($urandom_range(0, 40));
        1: c = RES_W'(RES_MAX - $urandom_range(0, 40));
        default: c = RES_W'($urandom_range(0, 32'(RES_MAX)));
      endcase
      r  = 10'($urandom_range(0, 1023));
      mx = $urandom_range(1, 8);
      for (int i = 0; i < mx; i++) begin
        v = longint'(c) + longint'($urandom_range(0, 2 * r + 40)) - longint'(r) - 20;
        if (v < 0) v = 0;
        if (v > RES_MAX) v = RES_MAX;
        res_q.push_back(RES_W'(v));
      end
      run_seq($sformatf("rand%0d", it), c, r, 4'($urandom_range(0, 4)), MEAS_W'(mx), 16'd0,
              $urandom_range(5, 12));
    end
  endtask

  task automatic test_async_reset;
    res_q.delete();
    @(negedge clk);
    det_mute = 1; pass_req = 4'd1; max_meas = 8'd0; timeout = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en("async_reset");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if ({det.o_meas_en, busy} !== 2'b00) begin miscompares++; $display("FAIL async_reset en_busy: got %b want 00", {det.o_meas_en, busy}); end
    @(negedge clk);
    rst = 1'b0;
    det_mute = 0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_exhaust();
    test_saturation();
    test_gap();
    test_stale_done();
    test_timeout();
    test_abort();
    test_done_wins();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule

// File: doc/ddr_pmon_lock_seq.md
Name: ddr_pmon_lock_seq

Overview:
- Measurement sequencer for the PMON frequency detector, which is enabled by `plllock_en` and returns `done` and `lockresult`.
- Runs repeated count windows by toggling the detector enable, and checks each captured PLL count against a programmable window (`i_cmp` ± `i_range`).
- Declares lock after a programmed number of consecutive in-range results; declares failure on attempt exhaustion or timeout.
- Sits in the PLL clock domain, beside the detector; CSR inputs are static while `o_busy`.

Parameters:
- RES_W, 24, detector result and compare width
- MEAS_W, 8, measurement attempt counter width
- TO_W, 16, per-measurement timeout counter width
- MIN_GAP, 4, minimum enable-low cycles between measurements (covers the detector's 2-flop enable synchroniser plus its edge flop)

Ports:
- i_clk  in  1  PLL-domain clock, same clock as the detector's `pllclk`
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  single-cycle pulse; begin a sequence (ignored while o_busy)
- i_abort  in  1  level; return to IDLE, no lock or fail flag set
- i_cmp  in  RES_W  expected PLL count per window
- i_range  in  10  allowed ± deviation
- i_pass_req  in  4  consecutive passes required; 0 treated as 1
- i_max_meas  in  MEAS_W  maximum attempts; 0 = unlimited
- i_timeout  in  TO_W  max cycles waiting for done; 0 = disabled
- i_gap  in  4  enable-low cycles between measurements; values below MIN_GAP use MIN_GAP
- i_meas_done  in  1  detector done
- i_meas_result  in  RES_W  detector lockresult
- o_meas_en  out  1  detector enable, registered
- o_busy  out  1  sequence active
- o_locked  out  1  sticky lock flag
- o_fail  out  1  sticky failure flag (attempts exhausted)
- o_timeout  out  1  sticky timeout flag (failure cause)
- o_last_result  out  RES_W  last evaluated result
- o_meas_cnt  out  MEAS_W  attempts completed, saturating
- o_pass_streak  out  4  current consecutive pass count

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States: IDLE, GAP, ARM, WAIT, EVAL, DONE.
- IDLE:
  - o_meas_en=0.
  - On i_start: clear o_locked, o_fail, o_timeout, o_meas_cnt, o_pass_streak; set o_busy; go to GAP.
- GAP:
  - o_meas_en=0 for max(i_gap, MIN_GAP) cycles, then ARM.
  - Guarantees the detector sees a fresh enable rising edge.
- ARM:
  - o_meas_en=1.
  - Stay at least 4 cycles AND until i_meas_done=0; this discards a stale done from the previous window.
  - Then go to WAIT; clear the timeout counter.
- WAIT:
  - o_meas_en=1.
  - On i_meas_done=1, go to EVAL.
  - If i_timeout≠0 and the counter reaches i_timeout: set o_timeout and o_fail, go to DONE.
  - If i_meas_done rises on the same cycle the timeout expires, done wins.
- EVAL (one cycle):
  - Latch i_meas_result into o_last_result; increment o_meas_cnt, saturating.
  - lo = i_cmp − i_range, saturating at 0; hi = i_cmp + i_range, saturating at 2^RES_W−1. Compute both at RES_W+1 bits.
  - Pass iff lo ≤ result ≤ hi (inclusive). A pass increments o_pass_streak, saturating at 15; a miss clears it.
  - If the streak ≥ effective pass_req: set o_locked, go to DONE.
  - Else if i_max_meas≠0 and o_meas_cnt (post-increment) ≥ i_max_meas: set o_fail, go to DONE.
  - Else go to GAP.
- DONE:
  - o_meas_en=0; o_busy=0; flags held.
  - i_start restarts the sequence as in IDLE.
- i_abort:
  - Highest priority in any state: go to IDLE, o_meas_en=0, o_busy=0.
  - Counters and flags hold their last values.
  - An i_start on the same cycle is ignored.
- i_start while o_busy: ignored.
- Async reset mid-sequence forces o_meas_en=0 immediately.

Optional Feature:
- Macro: DDR_PMON_LOCK_SEQ_HIST_EN.
- Defined:
  - Adds outputs o_min_result and o_max_result (RES_W each).
  - Updated in EVAL; initialised to all-ones/zero respectively at sequence start.
  - A first-measurement result overwrites both.
- Undefined: ports absent; no extra registers.

Decomposition:
- Package ddr_pmon_pkg:
  - state enum type `pmon_seq_state_t`
  - constant `PMON_MIN_GAP`
  - constant `PMON_RES_W`
- Sub-module ddr_pmon_win_cmp: combinational saturating window compare (cmp, range, result → pass).
- Instantiated once.

Test Plan:
- pass_req=3, cmp=1000, range=8, results 1005, 992, 1008 → o_locked=1 after third EVAL; o_meas_cnt=3; o_fail=0.
- pass_req=2, max_meas=4, results 1000, 1009, 1000, 991 → streak 1,0,1,0; o_fail=1 at cnt=4; o_locked=0.
- Saturation:
  - cmp=5, range=20, result=0 → pass (lo=0).
  - cmp=0xFFFFF0, range=0x3FF, result=0xFFFFFF → pass.
- timeout=50, done never asserts → o_timeout=1 and o_fail=1 exactly 50 cycles after WAIT entry; o_meas_en=0 next cycle.
- Stale done: i_meas_done held high into ARM for 3 cycles after enable → no EVAL until done has fallen and then re-risen.
- i_abort during WAIT → IDLE next cycle, o_meas_en=0, o_busy=0; a subsequent i_start clears flags and counters.
